fifo_sc_ext_m: RTL and testbench
================================

FIFO_SC_EXT_M -- requirements
Module: fifo_sc_ext_m

Interface
REQ-001 Parameter DATA_ITEM_TYPE, default logic, item type; W = $bits(DATA_ITEM_TYPE).
REQ-002 Parameter DEPTH, default 32, storage words; power of two, 4..65536.
REQ-003 Parameter FWFT, default 1; 1 = first-word-fall-through, 0 = standard read with 1-cycle latency.
REQ-004 Parameter AFULL_THRESH, default DEPTH-4; almost_full when count >= AFULL_THRESH.
REQ-005 Parameter AEMPTY_THRESH, default 4; almost_empty when count <= AEMPTY_THRESH.
REQ-006 Parameter CW = $clog2(DEPTH)+1, derived, count width.
REQ-007 Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents; flags and counters only.
- tail  in  W  write data.
- push  in  1  write request.
- head  out  W  read data.
- pop  in  1  read request.
- full  out  1  count == DEPTH.
- empty  out  1  no readable item at head.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  CW  items stored, 0..DEPTH.
- overflow  out  1  one-cycle pulse on rejected push.
- underflow  out  1  one-cycle pulse on rejected pop.

Function
REQ-008 Push accepted iff push && !full; pop accepted iff pop && !empty; no combinational dependency between push and pop acceptance.
REQ-009 Push && full: data dropped, overflow = 1 next cycle, state unchanged.
REQ-010 Pop && empty: underflow = 1 next cycle, state unchanged, head unchanged.
REQ-011 Write and read pointers are CW bits wide; address = low CW-1 bits; wrap from DEPTH-1 to 0 is natural rollover.
REQ-012 count = wr_ptr - rd_ptr (mod 2^CW); full/empty/almost flags registered, updated in the same cycle as count.
REQ-013 Simultaneous accepted push and pop: count unchanged, both pointers advance, including at count == 1 (FWFT) and across wrap.
REQ-014 FWFT=1: item pushed into empty FIFO appears on head, empty deasserts, one cycle after push; head valid whenever !empty; accepted pop presents next item next cycle.
REQ-015 FWFT=0: head updates one cycle after accepted pop and holds until next accepted pop; empty = count == 0.
REQ-016 Write-to-read latency (push to earliest pop acceptance) is exactly 1 cycle in both modes.
REQ-017 flush (synchronous, priority over push/pop in that cycle): pointers, count, flags to reset values next cycle; memory contents undefined.
REQ-018 Storage memory has no reset; head for FWFT=1 and empty is don't-care.

Reset
REQ-019 rst_n low asynchronously clears: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, head 0.
REQ-020 Reset mid-operation discards all items; first push after rst_n rises is accepted in the first clk edge after release.
REQ-021 Reset deassertion is synchronised externally; block has no reset-busy outputs.

Structure
REQ-022 Package fifo_pkg holds the CW derivation function and parameter legality checks (elaboration-time $error on non-power-of-two DEPTH or thresholds outside 0..DEPTH).
REQ-023 Storage in one sub-module ram_sdp_m (simple dual port, 1 write port, 1 registered or async read port per mode), inferable as LUTRAM or BRAM.
REQ-024 Pointer/flag logic, FWFT prefetch register and pulse flags live in fifo_sc_ext_m.

Verification
REQ-025 DEPTH=8, FWFT=1: push 0x11..0x18 back-to-back -> full=1 after 8th push, count=8, head=0x11; 9th push -> overflow pulse, count stays 8.
REQ-026 DEPTH=8, FWFT=1: pop 8 times from full -> head sequence 0x11..0x18, empty=1 after last; extra pop -> underflow pulse, count 0.
REQ-027 DEPTH=8, FWFT=0: push 0xA5, pop next cycle -> head=0xA5 one cycle after pop, empty=1.
REQ-028 DEPTH=8, count=8: push+pop same cycle -> push rejected, overflow=1, count=7; at count=4 push+pop for 20 cycles -> count stays 4, pointers wrap, data order preserved.
REQ-029 AFULL_THRESH=6, AEMPTY_THRESH=2: fill 0..8 -> almost_empty for count<=2, almost_full for count>=6, registered with count.
REQ-030 count=5: assert flush with push -> next cycle count=0, empty=1, push discarded; rst_n low mid-stream -> immediate reset values of REQ-019.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: count-width derivation and
// elaboration-time parameter legality checks.
package fifo_pkg;

    function automatic int calcCw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit isPow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit depthLegal(input int depth);
        return isPow2(depth) && (depth >= 4) && (depth <= 65536);
    endfunction

    function automatic bit threshLegal(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/ram_sdp_m.sv
// Simple dual-port storage: one write port, one registered read port with
// enable. The array itself is never reset so it maps onto LUTRAM or BRAM.
module ram_sdp_m #(
    parameter int W  = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [0:(2**AW)-1];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write on an address collision; the FIFO bypasses that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sc_ext_m.sv
// Single-clock FIFO with registered status flags, overflow/underflow pulses
// and either first-word-fall-through or one-cycle-latency standard reads.
module fifo_sc_ext_m
    import fifo_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  FWFT           = 1,
    parameter int  AFULL_THRESH   = DEPTH - 4,
    parameter int  AEMPTY_THRESH  = 4,
    parameter int  CW             = calcCw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  DATA_ITEM_TYPE tail,
    input  logic          push,
    output DATA_ITEM_TYPE head,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int W  = $bits(DATA_ITEM_TYPE);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (!depthLegal(DEPTH)) begin : gBadDepth
        $error("fifo_sc_ext_m: DEPTH=%0d must be a power of two in 4..65536", DEPTH);
    end
    if (!threshLegal(AFULL_THRESH, DEPTH) || !threshLegal(AEMPTY_THRESH, DEPTH)) begin : gBadThresh
        $error("fifo_sc_ext_m: thresholds must lie in 0..DEPTH");
    end

    logic [CW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, count_d;
    logic          full_q, empty_q, almostFull_q, almostEmpty_q;
    logic          overflow_q, underflow_q;
    logic          pushAcc, popAcc;
    logic [W-1:0]  tailBits, headBits, rdata;
    logic [AW-1:0] raddr;
    logic          ren;

    // Acceptance uses only registered flags, so push and pop never gate each other.
    assign pushAcc  = push && !full_q && !flush;
    assign popAcc   = pop && !empty_q && !flush;
    assign tailBits = tail;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (pushAcc) wrPtr_d = wrPtr_q + ONE;
            if (popAcc)  rdPtr_d = rdPtr_q + ONE;
        end
        count_d = wrPtr_d - rdPtr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            full_q        <= (count_d == DEPTH_C);
            empty_q       <= (count_d == '0);
            almostFull_q  <= (count_d >= AFULL_C);
            almostEmpty_q <= (count_d <= AEMPTY_C);
            overflow_q    <= push && full_q && !flush;
            underflow_q   <= pop && empty_q && !flush;
        end
    end

    ram_sdp_m #(
        .W  (W),
        .AW (AW)
    ) uRam (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (pushAcc),
        .waddr_i (wrPtr_q[AW-1:0]),
        .wdata_i (tailBits),
        .re_i    (ren),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    if (FWFT != 0) begin : gFwft
        logic         selBypass_q, selBypass_d;
        logic [W-1:0] bypass_q;

        // Prefetch the item that will be at the front after this edge; when that
        // item is being written right now the RAM cannot return it yet, so bypass.
        assign raddr       = rdPtr_d[AW-1:0];
        assign ren         = 1'b1;
        assign selBypass_d = pushAcc && (wrPtr_q == rdPtr_d);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                selBypass_q <= 1'b0;
                bypass_q    <= '0;
            end else begin
                selBypass_q <= selBypass_d;
                if (selBypass_d) bypass_q <= tailBits;
            end
        end

        assign headBits = selBypass_q ? bypass_q : rdata;
    end else begin : gStd
        assign raddr    = rdPtr_q[AW-1:0];
        assign ren      = popAcc;
        assign headBits = rdata;
    end

    assign head         = headBits;
    assign count        = wrPtr_q - rdPtr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sc_ext_m.sv
// Scoreboard bench: FWFT and standard instances share one random stimulus
// stream and are checked against a queue-based model of the FIFO.
module tb_fifo_sc_ext_m;

    localparam int DEPTH = 8;
    typedef logic [7:0] item_t;

    typedef struct {
        int    cnt;
        bit    full;
        bit    empty;
        bit    af1;
        bit    ae1;
        bit    af0;
        bit    ae0;
        bit    ov;
        bit    un;
        bit    headValid;
        item_t head1;
        item_t head0;
    } exp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  flush = 1'b0;
    logic  push  = 1'b0;
    logic  pop   = 1'b0;
    item_t tail  = '0;

    item_t       head1, head0;
    logic        full1, empty1, almostFull1, almostEmpty1, overflow1, underflow1;
    logic        full0, empty0, almostFull0, almostEmpty0, overflow0, underflow0;
    logic [3:0]  count1, count0;

    item_t model[$];
    item_t lastPop = '0;
    exp_t  expQ[$];
    int    checkCount = 0;
    int    passCount  = 0;

    always #5 clk = ~clk;

    fifo_sc_ext_m #(
        .DATA_ITEM_TYPE (item_t),
        .DEPTH          (DEPTH),
        .FWFT           (1),
        .AFULL_THRESH   (6),
        .AEMPTY_THRESH  (2)
    ) dutFwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .tail         (tail),
        .push         (push),
        .head         (head1),
        .pop          (pop),
        .full         (full1),
        .empty        (empty1),
        .almost_full  (almostFull1),
        .almost_empty (almostEmpty1),
        .count        (count1),
        .overflow     (overflow1),
        .underflow    (underflow1)
    );

    fifo_sc_ext_m #(
        .DATA_ITEM_TYPE (item_t),
        .DEPTH          (DEPTH),
        .FWFT           (0)
    ) dutStd (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .tail         (tail),
        .push         (push),
        .head         (head0),
        .pop          (pop),
        .full         (full0),
        .empty        (empty0),
        .almost_full  (almostFull0),
        .almost_empty (almostEmpty0),
        .count        (count0),
        .overflow     (overflow0),
        .underflow    (underflow0)
    );

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("count fwft", count1, e.cnt);
        checkValue("count std", count0, e.cnt);
        checkValue("full fwft", full1, e.full);
        checkValue("full std", full0, e.full);
        checkValue("empty fwft", empty1, e.empty);
        checkValue("empty std", empty0, e.empty);
        checkValue("almost_full fwft", almostFull1, e.af1);
        checkValue("almost_empty fwft", almostEmpty1, e.ae1);
        checkValue("almost_full std", almostFull0, e.af0);
        checkValue("almost_empty std", almostEmpty0, e.ae0);
        checkValue("overflow fwft", overflow1, e.ov);
        checkValue("overflow std", overflow0, e.ov);
        checkValue("underflow fwft", underflow1, e.un);
        checkValue("underflow std", underflow0, e.un);
        checkValue("head std", head0, e.head0);
        if (e.headValid) checkValue("head fwft", head1, e.head1);
    endtask

    task automatic checkReset();
        checkValue("reset count fwft", count1, 0);
        checkValue("reset count std", count0, 0);
        checkValue("reset flags fwft", {full1, empty1, almostFull1, almostEmpty1, overflow1, underflow1}, 6'b010100);
        checkValue("reset flags std", {full0, empty0, almostFull0, almostEmpty0, overflow0, underflow0}, 6'b010100);
        checkValue("reset head fwft", head1, 0);
        checkValue("reset head std", head0, 0);
    endtask

    // Called just after a falling edge; models the upcoming rising edge.
    task automatic applyStimulus(input bit doPush, input bit doPop, input bit doFlush, input item_t data);
        exp_t e;
        bit   pushOk, popOk;
        int   size;
        push  = doPush;
        pop   = doPop;
        flush = doFlush;
        tail  = data;
        size   = model.size();
        e.ov   = doPush && !doFlush && (size == DEPTH);
        e.un   = doPop && !doFlush && (size == 0);
        pushOk = doPush && !doFlush && (size < DEPTH);
        popOk  = doPop && !doFlush && (size > 0);
        if (doFlush) begin
            model.delete();
        end else begin
            if (popOk) lastPop = model.pop_front();
            if (pushOk) model.push_back(data);
        end
        size        = model.size();
        e.cnt       = size;
        e.full      = (size == DEPTH);
        e.empty     = (size == 0);
        e.af1       = (size >= 6);
        e.ae1       = (size <= 2);
        e.af0       = (size >= DEPTH - 4);
        e.ae0       = (size <= 4);
        e.headValid = (size > 0);
        e.head1     = (size > 0) ? model[0] : '0;
        e.head0     = lastPop;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #2;
        checkReset();
        model.delete();
        lastPop = '0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetPulse();

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, item_t'(8'h11 + i));
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, item_t'($urandom));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, item_t'($urandom));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h78);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, item_t'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, item_t'($urandom));
        resetPulse();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 3,
                          item_t'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
